// File: rtl/test_result_logger_pkg.sv
// Shared definitions for the test result logger: controller states, display
// source codes, counter geometry and the saturating increment.
package test_result_logger_pkg;

  localparam int NUM_CHAINS = 22;
  localparam int CNT_MAX    = 9999;
  localparam int CNT_W      = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] VIEW_TESTS  = 2'd0;
  localparam logic [1:0] VIEW_ERRORS = 2'd1;
  localparam logic [1:0] VIEW_FIRST  = 2'd2;
  localparam logic [1:0] VIEW_CHAINS = 2'd3;

  // Counters stop at the display limit instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                               input int max);
    return (int'(value) >= max) ? value : value + CNT_W'(1);
  endfunction

endpackage

// File: rtl/test_result_logger_bin2bcd_seq.sv
// Sequential shift-add-3 binary to 4-digit BCD converter. A start while idle
// loads the operand; bcd updates exactly 16 cycles later, in the cycle after done.
module bin2bcd_seq
  import test_result_logger_pkg::*;
(
  input  logic             sys_clock,
  input  logic             sys_reset,
  input  logic             start,
  input  logic [CNT_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd
);

  logic [CNT_W-1:0]  bin_sr;
  logic [15:0]       acc;
  logic [15:0]       acc_adj;
  logic [3:0]        step;
  logic [CNT_W+15:0] shifted;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < 4; d++) begin
      if (acc[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
  end

  assign shifted = {acc_adj, bin_sr} << 1;
  assign done    = busy && (step == 4'(CNT_W));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge sys_clock or negedge sys_reset) begin
    if (!sys_reset) begin
      bin_sr <= '0;
      acc    <= '0;
      step   <= '0;
      busy   <= 1'b0;
      bcd    <= '0;
    end else if (start && !busy) begin
      bin_sr <= bin;
      acc    <= '0;
      step   <= '0;
      busy   <= 1'b1;
    end else if (done) begin
      bcd  <= acc;
      busy <= 1'b0;
    end else if (busy) begin
      acc    <= shifted[CNT_W+15:CNT_W];
      bin_sr <= shifted[CNT_W-1:0];
      step   <= step + 4'd1;
    end
  end

endmodule

// File: rtl/test_result_logger.sv
// Logs pass/fail steps from an asynchronous pattern generator, keeps a failing
// chain map and first-fail record, and shows a selected value as BCD.
module test_result_logger #(
  parameter int NUM_CHAINS  = test_result_logger_pkg::NUM_CHAINS,
  parameter int CNT_MAX     = test_result_logger_pkg::CNT_MAX,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  sys_clock,
  input  logic                  sys_reset,
  input  logic                  test_clock,
  input  logic                  error_flag,
  input  logic [5:0]            k_pattern,
  input  logic [4:0]            chain_sel,
  input  logic                  stop,
  input  logic                  continua,
  input  logic [1:0]            view_sel,
  output logic [14:0]           total_tests,
  output logic [14:0]           total_errors,
  output logic [NUM_CHAINS-1:0] fail_map,
  output logic                  first_fail_valid,
  output logic [4:0]            first_fail_chain,
  output logic [5:0]            first_fail_k,
  output logic [1:0]            state,
  output logic [15:0]           bcd,
  output logic                  bcd_valid
);
  import test_result_logger_pkg::*;

  logic [SYNC_STAGES-1:0] tc_sync, stop_sync, cont_sync;
  logic                   tc_prev, cont_prev;
  logic                   tc_fall, cont_rise, stop_s;
  logic                   sample_q, cap_err;
  logic [5:0]             cap_k;
  logic [4:0]             cap_chain;
  logic                   final_step, chain_in_range, log_step;
  state_t                 state_q;

  logic [CNT_W-1:0] view_value, last_value;
  logic [1:0]       last_view;
  logic             need_conv, valid_q, conv_pending, conv_start;
  logic             conv_busy, conv_done;

  assign stop_s    = stop_sync[SYNC_STAGES-1];
  assign tc_fall   = tc_prev && !tc_sync[SYNC_STAGES-1];
  assign cont_rise = cont_sync[SYNC_STAGES-1] && !cont_prev;

  // Inputs are captured on the cycle the fall is seen and logged one cycle later.
  always_ff @(posedge sys_clock or negedge sys_reset) begin
    if (!sys_reset) begin
      tc_sync   <= '0;
      stop_sync <= '0;
      cont_sync <= '0;
      tc_prev   <= 1'b0;
      cont_prev <= 1'b0;
      sample_q  <= 1'b0;
      cap_err   <= 1'b0;
      cap_k     <= '0;
      cap_chain <= '0;
    end else begin
      tc_sync   <= {tc_sync[SYNC_STAGES-2:0], test_clock};
      stop_sync <= {stop_sync[SYNC_STAGES-2:0], stop};
      cont_sync <= {cont_sync[SYNC_STAGES-2:0], continua};
      tc_prev   <= tc_sync[SYNC_STAGES-1];
      cont_prev <= cont_sync[SYNC_STAGES-1];
      sample_q  <= tc_fall;
      if (tc_fall) begin
        cap_err   <= error_flag;
        cap_k     <= k_pattern;
        cap_chain <= chain_sel;
      end
    end
  end

  assign final_step     = (int'(cap_chain) == NUM_CHAINS - 1) && (cap_k == 6'd63);
  assign chain_in_range = int'(cap_chain) < NUM_CHAINS;
  assign log_step       = sample_q && ((state_q == ST_IDLE) || (state_q == ST_RUN));

  always_ff @(posedge sys_clock or negedge sys_reset) begin
    if (!sys_reset) begin
      state_q          <= ST_IDLE;
      total_tests      <= '0;
      total_errors     <= '0;
      fail_map         <= '0;
      first_fail_valid <= 1'b0;
      first_fail_chain <= '0;
      first_fail_k     <= '0;
    end else begin
      if (log_step) begin
        total_tests <= sat_inc(total_tests, CNT_MAX);
        if (cap_err) begin
          total_errors <= sat_inc(total_errors, CNT_MAX);
          if (chain_in_range) fail_map[cap_chain] <= 1'b1;
          if (!first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_chain <= cap_chain;
            first_fail_k     <= cap_k;
          end
        end
      end
      // The final sweep sample wins over a simultaneous stop.
      case (state_q)
        ST_IDLE: if (sample_q) state_q <= ST_RUN;
        ST_RUN: begin
          if (sample_q && final_step) state_q <= ST_DONE;
          else if (stop_s)            state_q <= ST_HALT;
        end
        ST_HALT: if (cont_rise && !stop_s) state_q <= ST_RUN;
        ST_DONE: begin
          if (cont_rise) begin
            total_tests      <= '0;
            total_errors     <= '0;
            fail_map         <= '0;
            first_fail_valid <= 1'b0;
            first_fail_chain <= '0;
            first_fail_k     <= '0;
            state_q          <= ST_RUN;
          end
        end
      endcase
    end
  end

  assign state = state_q;

  always_comb begin
    view_value = total_tests;
    case (view_sel)
      VIEW_TESTS:  view_value = total_tests;
      VIEW_ERRORS: view_value = total_errors;
      VIEW_FIRST:  view_value = CNT_W'(first_fail_chain) * CNT_W'(100) + CNT_W'(first_fail_k);
      VIEW_CHAINS: view_value = CNT_W'($countones(fail_map));
    endcase
  end

  // A conversion is owed whenever the displayed source differs from the one
  // last handed to the converter; need_conv forces one after reset.
  assign conv_pending = need_conv || (view_value != last_value) || (view_sel != last_view);
  assign conv_start   = conv_pending && !conv_busy;
  assign bcd_valid    = valid_q && !conv_pending;

  always_ff @(posedge sys_clock or negedge sys_reset) begin
    if (!sys_reset) begin
      last_value <= '0;
      last_view  <= '0;
      need_conv  <= 1'b1;
      valid_q    <= 1'b0;
    end else if (conv_start) begin
      last_value <= view_value;
      last_view  <= view_sel;
      need_conv  <= 1'b0;
      valid_q    <= 1'b0;
    end else if (conv_done) begin
      valid_q <= 1'b1;
    end
  end

  bin2bcd_seq u_bin2bcd (
    .sys_clock (sys_clock),
    .sys_reset (sys_reset),
    .start     (conv_start),
    .bin       (view_value),
    .busy      (conv_busy),
    .done      (conv_done),
    .bcd       (bcd)
  );

endmodule

// File: tb/tb_test_result_logger.sv
// Randomized bench for test_result_logger against a step-level reference model
// of counters, fail map, first-fail record, controller state and BCD display.
module tb_test_result_logger;

  localparam int NCH  = 22;
  localparam int CMAX = 9999;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_DONE = 3;

  logic        sys_clock = 1'b0;
  logic        sys_reset = 1'b0;
  logic        test_clock = 1'b0;
  logic        error_flag = 1'b0;
  logic [5:0]  k_pattern = '0;
  logic [4:0]  chain_sel = '0;
  logic        stop = 1'b0;
  logic        continua = 1'b0;
  logic [1:0]  view_sel = '0;
  logic [14:0] total_tests, total_errors;
  logic [21:0] fail_map;
  logic        first_fail_valid;
  logic [4:0]  first_fail_chain;
  logic [5:0]  first_fail_k;
  logic [1:0]  state;
  logic [15:0] bcd;
  logic        bcd_valid;

  test_result_logger dut (
    .sys_clock        (sys_clock),
    .sys_reset        (sys_reset),
    .test_clock       (test_clock),
    .error_flag       (error_flag),
    .k_pattern        (k_pattern),
    .chain_sel        (chain_sel),
    .stop             (stop),
    .continua         (continua),
    .view_sel         (view_sel),
    .total_tests      (total_tests),
    .total_errors     (total_errors),
    .fail_map         (fail_map),
    .first_fail_valid (first_fail_valid),
    .first_fail_chain (first_fail_chain),
    .first_fail_k     (first_fail_k),
    .state            (state),
    .bcd              (bcd),
    .bcd_valid        (bcd_valid)
  );

  always #5 sys_clock = ~sys_clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain counts and flags updated per logged step.
  int        m_state, m_tests, m_errors, m_ff_chain, m_ff_k;
  bit        m_ff_valid;
  bit [21:0] m_map;

  function automatic void m_clear();
    m_tests = 0; m_errors = 0; m_map = '0;
    m_ff_valid = 1'b0; m_ff_chain = 0; m_ff_k = 0;
  endfunction

  function automatic void m_sample(input bit e, input int k, input int c, input bit stop_now);
    if (m_state == M_IDLE || m_state == M_RUN) begin
      m_tests = (m_tests < CMAX) ? m_tests + 1 : CMAX;
      if (e) begin
        m_errors = (m_errors < CMAX) ? m_errors + 1 : CMAX;
        if (c < NCH) m_map[c] = 1'b1;
        if (!m_ff_valid) begin
          m_ff_valid = 1'b1; m_ff_chain = c; m_ff_k = k;
        end
      end
      if (m_state == M_RUN && c == NCH - 1 && k == 63) m_state = M_DONE;
      else if (m_state == M_RUN && stop_now)          m_state = M_HALT;
      else                                             m_state = M_RUN;
    end
  endfunction

  function automatic int m_view(input int vs);
    case (vs)
      0:       return m_tests;
      1:       return m_errors;
      2:       return m_ff_chain * 100 + m_ff_k;
      default: return $countones(m_map);
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // One pattern-generator step; the DUT has logged it by the time this returns.
  task automatic do_step(input bit e, input int k, input int c, input bit stop_mid);
    error_flag = e;
    k_pattern  = 6'(k);
    chain_sel  = 5'(c);
    test_clock = 1'b1;
    repeat (2) @(negedge sys_clock);
    test_clock = 1'b0;
    @(negedge sys_clock);
    if (stop_mid) stop = 1'b1;
    repeat (3) @(negedge sys_clock);
    m_sample(e, k, c, stop_mid);
  endtask

  task automatic set_stop(input bit v);
    stop = v;
    repeat (4) @(negedge sys_clock);
    if (v && m_state == M_RUN) m_state = M_HALT;
  endtask

  task automatic pulse_continua();
    continua = 1'b1;
    repeat (4) @(negedge sys_clock);
    continua = 1'b0;
    repeat (4) @(negedge sys_clock);
    if (m_state == M_HALT && !stop) m_state = M_RUN;
    else if (m_state == M_DONE) begin
      m_clear();
      m_state = M_RUN;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"},  32'(state),            32'(m_state));
    check({tag, ".tests"},  32'(total_tests),      32'(m_tests));
    check({tag, ".errors"}, 32'(total_errors),     32'(m_errors));
    check({tag, ".map"},    32'(fail_map),         32'(m_map));
    check({tag, ".ffv"},    32'(first_fail_valid), 32'(m_ff_valid));
    check({tag, ".ffc"},    32'(first_fail_chain), 32'(m_ff_chain));
    check({tag, ".ffk"},    32'(first_fail_k),     32'(m_ff_k));
  endtask

  task automatic check_bcd(input int vs, input string tag);
    int n;
    n = 0;
    view_sel = 2'(vs);
    #1;
    while (!bcd_valid && n < 64) begin
      @(negedge sys_clock);
      n++;
    end
    check({tag, ".valid"}, 32'(bcd_valid), 32'd1);
    check({tag, ".bcd"},   32'(bcd),       32'(to_bcd(m_view(vs))));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".state"},  32'(state),            32'd0);
    check({tag, ".tests"},  32'(total_tests),      32'd0);
    check({tag, ".errors"}, 32'(total_errors),     32'd0);
    check({tag, ".map"},    32'(fail_map),         32'd0);
    check({tag, ".ffv"},    32'(first_fail_valid), 32'd0);
    check({tag, ".ffc"},    32'(first_fail_chain), 32'd0);
    check({tag, ".ffk"},    32'(first_fail_k),     32'd0);
    check({tag, ".bcd"},    32'(bcd),              32'd0);
    check({tag, ".bvalid"}, 32'(bcd_valid),        32'd0);
  endtask

  task automatic release_and_wait_bcd(input string tag);
    bit seen;
    seen = 1'b0;
    @(negedge sys_clock);
    sys_reset = 1'b1;
    for (int n = 0; n < 17 && !seen; n++) begin
      @(posedge sys_clock);
      #1;
      seen = bcd_valid;
    end
    check({tag, ".valid17"}, 32'(seen), 32'd1);
    check({tag, ".bcd0"},    32'(bcd),  32'd0);
  endtask

  logic [15:0] old_bcd;
  bit          e;
  int          c, k;

  initial begin
    m_state = M_IDLE;
    m_clear();

    repeat (3) @(negedge sys_clock);
    check_reset_outputs("rst");
    release_and_wait_bcd("rel");

    // Ten clean steps from IDLE.
    for (int i = 0; i < 10; i++) do_step(1'b0, $urandom_range(0, 62), $urandom_range(0, 31), 1'b0);
    check_all("clean10");
    check("clean10.tests_abs", 32'(total_tests), 32'd10);

    // Two failures with clean steps in between; only the first is recorded.
    do_step(1'b1, 17, 3, 1'b0);
    for (int i = 0; i < 3; i++) do_step(1'b0, $urandom_range(0, 62), $urandom_range(0, 20), 1'b0);
    do_step(1'b1, 2, 5, 1'b0);
    check_all("ff");
    check("ff.map_abs", 32'(fail_map), 32'h28);
    check("ff.first_abs", {first_fail_chain, first_fail_k}, {5'd3, 6'd17});

    // Exact conversion latency: new digits appear on the 16th edge after start.
    check_bcd(0, "v0");
    old_bcd = to_bcd(m_view(0));
    @(negedge sys_clock);
    view_sel = 2'd2;
    repeat (16) @(posedge sys_clock);
    #1;
    check("lat.before", 32'(bcd), 32'(old_bcd));
    check("lat.busy",   32'(bcd_valid), 32'd0);
    @(posedge sys_clock);
    #1;
    check("lat.bcd",    32'(bcd), 32'h0317);
    check("lat.valid",  32'(bcd_valid), 32'd1);

    // Random steps, including out-of-range chains and occasional final samples.
    for (int i = 0; i < 150; i++) begin
      e = ($urandom_range(0, 3) == 0);
      c = $urandom_range(0, 31);
      k = $urandom_range(0, 63);
      if ($urandom_range(0, 24) == 0) begin
        c = NCH - 1;
        k = 63;
      end
      do_step(e, k, c, 1'b0);
      check_all("rnd");
      if (m_state == M_DONE) begin
        pulse_continua();
        check_all("rnd.clr");
      end
      if (i % 30 == 29) check_bcd((i / 30) % 4, "rnd.bcd");
    end

    // Paused steps are dropped; resume keeps every record.
    set_stop(1'b1);
    check("halt.state", 32'(state), 32'd2);
    for (int i = 0; i < 5; i++) do_step(1'b1, $urandom_range(0, 62), $urandom_range(0, 21), 1'b0);
    check_all("halt");
    set_stop(1'b0);
    pulse_continua();
    check_all("resume");
    check("resume.state", 32'(state), 32'd1);

    // Final sample coinciding with stop: logged, and DONE wins.
    do_step(1'b0, 63, NCH - 1, 1'b1);
    check_all("coinc");
    check("coinc.state", 32'(state), 32'd3);
    set_stop(1'b0);
    pulse_continua();
    check_all("clr");
    check("clr.tests_abs", 32'(total_tests), 32'd0);

    // Full sweep ends in DONE; extra steps ignored; continua clears.
    for (int ch = 0; ch < NCH; ch++)
      for (int kk = 0; kk < 64; kk++)
        do_step(($urandom_range(0, 7) == 0), kk, ch, 1'b0);
    check_all("sweep");
    check("sweep.tests_abs", 32'(total_tests), 32'd1408);
    check("sweep.state", 32'(state), 32'd3);
    for (int i = 0; i < 3; i++) do_step(1'b1, $urandom_range(0, 63), $urandom_range(0, 21), 1'b0);
    check_all("done.extra");
    check("done.extra_abs", 32'(total_tests), 32'd1408);
    pulse_continua();
    check_all("done.clr");
    check("done.clr_abs", 32'(state), 32'd1);

    // Saturation of both counters.
    for (int i = 0; i < 10005; i++) begin
      do_step(1'b1, $urandom_range(0, 62), $urandom_range(0, 21), 1'b0);
      if (i % 2500 == 2499) check_all("sat");
    end
    check_all("sat.end");
    check("sat.errors_abs", 32'(total_errors), 32'd9999);
    check_bcd(1, "sat.bcd");
    check("sat.bcd_abs", 32'(bcd), 32'h9999);

    // Reset in RUN during a conversion.
    @(negedge sys_clock);
    view_sel = 2'd3;
    repeat (5) @(posedge sys_clock);
    #2;
    sys_reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    m_state = M_IDLE;
    m_clear();
    repeat (2) @(negedge sys_clock);
    release_and_wait_bcd("rel2");
    for (int i = 0; i < 3; i++) do_step(1'b1, $urandom_range(0, 62), $urandom_range(0, 31), 1'b0);
    check_all("post");
    check_bcd(3, "post.bcd");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/test_result_logger.md
TEST_RESULT_LOGGER -- requirements
Module: test_result_logger

Interface
REQ-001 Parameter NUM_CHAINS, 22, number of chains addressed by chain_sel (0..NUM_CHAINS-1).
REQ-002 Parameter CNT_MAX, 9999, saturation value of both result counters (4-digit display limit).
REQ-003 Parameter SYNC_STAGES, 2, flip-flop depth of the test_clock/stop/continua synchronisers.
REQ-004 sys_clock  in  1  system clock; all logic on its rising edge.
REQ-005 sys_reset  in  1  reset, asynchronous, active-low.
REQ-006 test_clock  in  1  slow step clock from the pattern generator, asynchronous to sys_clock.
REQ-007 error_flag  in  1  comparison result for the current step; 1 = mismatch.
REQ-008 k_pattern  in  6  pattern value K applied in the current step.
REQ-009 chain_sel  in  5  chain index under test.
REQ-010 stop  in  1  level; 1 = pause logging.
REQ-011 continua  in  1  resume/restart request; acts on its rising edge.
REQ-012 view_sel  in  2  display source: 0 total_tests, 1 total_errors, 2 first_fail_chain*100+first_fail_k, 3 failing-chain count.
REQ-013 total_tests  out  15  steps logged, saturating.
REQ-014 total_errors  out  15  failing steps logged, saturating.
REQ-015 fail_map  out  NUM_CHAINS  bit n = chain n has failed at least once.
REQ-016 first_fail_valid / first_fail_chain[4:0] / first_fail_k[5:0]  out  record of the first failing step.
REQ-017 state  out  2  IDLE=0, RUN=1, HALT=2, DONE=3.
REQ-018 bcd  out  16  four BCD digits of the selected value; bcd_valid  out  1  bcd is current.

Function
REQ-019 test_clock, stop and continua SHALL each pass through a SYNC_STAGES synchroniser before use; edges are detected on synchronised values only.
REQ-020 A step sample SHALL occur on one sys_clock cycle after each detected falling edge of synchronised test_clock, capturing error_flag, k_pattern and chain_sel.
REQ-021 IDLE: the first step sample SHALL transition to RUN and be logged in that same cycle.
REQ-022 RUN: each step sample SHALL increment total_tests; if error_flag=1, it SHALL also increment total_errors and set fail_map[chain_sel].
REQ-023 The first failing step since clear SHALL load first_fail_chain/k and set first_fail_valid; later failures SHALL leave it unchanged.
REQ-024 Counters SHALL hold at CNT_MAX once reached; no wrap.
REQ-025 A sample with chain_sel >= NUM_CHAINS SHALL count in total_tests/total_errors but SHALL NOT modify fail_map.
REQ-026 RUN with synchronised stop=1 SHALL go to HALT; samples in HALT SHALL be ignored.
REQ-027 HALT SHALL return to RUN on a continua rising edge while stop=0, with all records kept.
REQ-028 RUN: a logged sample with chain_sel=NUM_CHAINS-1 and k_pattern=63 SHALL go to DONE after logging it.
REQ-029 DONE SHALL ignore samples; a continua rising edge SHALL clear all counters, fail_map and the first-fail record, then enter RUN.
REQ-030 If stop and the final sweep sample coincide, the sample SHALL be logged and DONE SHALL take priority over HALT.
REQ-031 A BCD conversion of the view_sel-selected value SHALL start whenever that value or view_sel changes; bcd_valid SHALL be low from start until the result loads.
REQ-032 The conversion SHALL be sequential shift-add-3 over 15 bits, with bcd updated exactly 16 cycles after the start.
REQ-033 A change of value during a conversion SHALL cause a restart with the new value once the current conversion completes; the result is never stale when bcd_valid=1.

Reset
REQ-034 While sys_reset=0: state=IDLE, counters=0, fail_map=0, first_fail_*=0, bcd=0, bcd_valid=0, synchronisers=0.
REQ-035 Reset mid-conversion or mid-run SHALL discard all progress; the first conversion after release SHALL start without a value change.

Structure
REQ-036 The shared package SHALL hold the state encoding, NUM_CHAINS, CNT_MAX, the 15-bit count width and the view_sel codes.
REQ-037 The BCD converter SHALL be a separate sub-module, bin2bcd_seq (start/busy/done handshake).

Verification
REQ-038 Reset, then 10 test_clock periods with error_flag=0 -> total_tests=10, total_errors=0, state=RUN, first_fail_valid=0.
REQ-039 Failures at (chain 3, K 17) and then (chain 5, K 2) -> first_fail=(3,17), fail_map=0x000028, total_errors=2; view_sel=2 -> bcd=0x0317 after 16 cycles.
REQ-040 Full sweep of 22x64 steps -> total_tests=1408, state=DONE; extra test_clock edges leave the counts unchanged; a continua pulse -> all counts 0, state=RUN.
REQ-041 stop=1 for 5 steps, then stop=0 plus a continua pulse -> those 5 steps are not counted and state returns to RUN.
REQ-042 Forced error on 10005 steps -> total_errors=9999 and held there; bcd=0x9999.
REQ-043 sys_reset asserted during a BCD conversion and in RUN -> all outputs go to reset values immediately, and bcd_valid returns to 1 within 17 cycles after release.
